// File: rtl/vga_line_reader.sv
// vga_line_reader: reads the ping-pong pixel bank selected by readVgaSelector,
// serialises its packed 8-bit pixels onto a registered RGB stream at the
// pixel-enable rate, and swaps banks once the other bank is full.
// Optional feature: define VGA_UNDERRUN_COUNT_EN to build the saturating
// underrun counter; otherwise underrun_count is tied to zero.
module vga_line_reader #(
   parameter int PIXELS = 16,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pix_en,
   input  logic                active,
   input  logic [8*PIXELS-1:0] R_inRegA,
   input  logic [8*PIXELS-1:0] G_inRegA,
   input  logic [8*PIXELS-1:0] B_inRegA,
   input  logic [8*PIXELS-1:0] R_inRegB,
   input  logic [8*PIXELS-1:0] G_inRegB,
   input  logic [8*PIXELS-1:0] B_inRegB,
   input  logic                bankA_full,
   input  logic                bankB_full,
   output logic                readVgaSelector,
   output logic [7:0]          R_out,
   output logic [7:0]          G_out,
   output logic [7:0]          B_out,
   output logic                pixel_valid,
   output logic                bank_done,
   output logic                underrun,
   output logic [CNT_W-1:0]    underrun_count
);

   localparam int               IDX_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      STALL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             sel_q, sel_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             under_q, under_d;

   logic             emit;
   logic             other_full;
   logic             last_px;

   logic [7:0]       ra [PIXELS];
   logic [7:0]       ga [PIXELS];
   logic [7:0]       ba [PIXELS];
   logic [7:0]       rb [PIXELS];
   logic [7:0]       gb [PIXELS];
   logic [7:0]       bb [PIXELS];

   // Unpack both banks into per-pixel arrays so idx can index them directly
   for (genvar p = 0; p < PIXELS; p++) begin : g_unpack
      assign ra[p] = R_inRegA[8*p +: 8];
      assign ga[p] = G_inRegA[8*p +: 8];
      assign ba[p] = B_inRegA[8*p +: 8];
      assign rb[p] = R_inRegB[8*p +: 8];
      assign gb[p] = G_inRegB[8*p +: 8];
      assign bb[p] = B_inRegB[8*p +: 8];
   end

   assign emit       = pix_en & active;
   assign other_full = sel_q ? bankA_full : bankB_full;
   assign last_px    = (idx_q == LAST_IDX);

   // State register plus all registered outputs; reset returns to IDLE reading B
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= 1'b1;
         idx_q   <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         under_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         under_q <= under_d;
      end
   end

   // Next state: advance idx per streamed slot, swap banks only at the end of a bank
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it
      // unassigned and infers a latch.
      state_d = state_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bankA_full) begin
               state_d = STREAM;
               sel_d   = 1'b0;
               idx_d   = '0;
            end
         end
         STREAM: begin
            if (emit) begin
               if (last_px) begin
                  if (other_full) begin
                     sel_d = ~sel_q;
                     idx_d = '0;
                  end else begin
                     state_d = STALL;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         STALL: begin
            if (other_full) begin
               state_d = STREAM;
               sel_d   = ~sel_q;
               idx_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output values: bank pixel on a streaming slot, black on every other pixel slot
   always_comb begin
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      under_d = 1'b0;
      if (pix_en) begin
         if (emit && (state_q == STREAM)) begin
            r_d     = sel_q ? rb[idx_q] : ra[idx_q];
            g_d     = sel_q ? gb[idx_q] : ga[idx_q];
            b_d     = sel_q ? bb[idx_q] : ba[idx_q];
            valid_d = 1'b1;
            done_d  = last_px;
         end else begin
            r_d     = '0;
            g_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
            under_d = emit && (state_q == STALL);
         end
      end
   end

`ifdef VGA_UNDERRUN_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of underrun pixels; only reset clears it
   always_comb begin
      cnt_d = cnt_q;
      if (under_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Underrun counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign underrun_count = cnt_q;
`else
   assign underrun_count = '0;
`endif

   assign readVgaSelector = sel_q;
   assign R_out           = r_q;
   assign G_out           = g_q;
   assign B_out           = b_q;
   assign pixel_valid     = valid_q;
   assign bank_done       = done_q;
   assign underrun        = under_q;

endmodule

// File: tb/tb_vga_line_reader.sv
// Directed testbench for vga_line_reader: startup, seamless swap, underrun,
// blanking at half pixel rate, mid-stream reset and counter saturation.
module tb_vga_line_reader;

   localparam int PIXELS   = 16;
   localparam int TB_CNT_W = 4;

   logic                clk;
   logic                reset;
   logic                pix_en;
   logic                active;
   logic [8*PIXELS-1:0] R_inRegA, G_inRegA, B_inRegA;
   logic [8*PIXELS-1:0] R_inRegB, G_inRegB, B_inRegB;
   logic                bankA_full, bankB_full;
   logic                readVgaSelector;
   logic [7:0]          R_out, G_out, B_out;
   logic                pixel_valid, bank_done, underrun;
   logic [TB_CNT_W-1:0] underrun_count;

   int checks = 0;
   int errors = 0;

   vga_line_reader #(.PIXELS(PIXELS), .CNT_W(TB_CNT_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .pix_en          (pix_en),
      .active          (active),
      .R_inRegA        (R_inRegA),
      .G_inRegA        (G_inRegA),
      .B_inRegA        (B_inRegA),
      .R_inRegB        (R_inRegB),
      .G_inRegB        (G_inRegB),
      .B_inRegB        (B_inRegB),
      .bankA_full      (bankA_full),
      .bankB_full      (bankB_full),
      .readVgaSelector (readVgaSelector),
      .R_out           (R_out),
      .G_out           (G_out),
      .B_out           (B_out),
      .pixel_valid     (pixel_valid),
      .bank_done       (bank_done),
      .underrun        (underrun),
      .underrun_count  (underrun_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected pixel k of bank A: R fixed, G and B encode the index
   function automatic logic [23:0] px_a(input int k);
      return {8'h17, 8'(k), 8'(8'hA0 + k)};
   endfunction

   // Expected pixel k of bank B: pixel 0 is (0x87,0x32,0x50)
   function automatic logic [23:0] px_b(input int k);
      return {8'(8'h87 + k), 8'(8'h32 + k), 8'(8'h50 + k)};
   endfunction

   // Expected counter after n underrun pixels since reset
   function automatic logic [TB_CNT_W-1:0] exp_cnt(input int n);
`ifdef VGA_UNDERRUN_COUNT_EN
      return (n > 15) ? 4'hF : TB_CNT_W'(n);
`else
      return (n > 0) ? '0 : '0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_out(input string tag, input logic [23:0] rgb, input logic v,
                          input logic d, input logic u, input logic s);
      check({tag, " R"},     32'(R_out),           32'(rgb[23:16]));
      check({tag, " G"},     32'(G_out),           32'(rgb[15:8]));
      check({tag, " B"},     32'(B_out),           32'(rgb[7:0]));
      check({tag, " valid"}, 32'(pixel_valid),     32'(v));
      check({tag, " done"},  32'(bank_done),       32'(d));
      check({tag, " under"}, 32'(underrun),        32'(u));
      check({tag, " sel"},   32'(readVgaSelector), 32'(s));
   endtask

   task automatic chk_cnt(input string tag, input logic [TB_CNT_W-1:0] e);
      check({tag, " count"}, 32'(underrun_count), 32'(e));
   endtask

   // One clock with the given enables; outputs are sampled 1 time unit after the edge
   task automatic cyc(input logic pe, input logic act);
      pix_en = pe;
      active = act;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [23:0] pa, pb;
      reset = 1'b1;
      pix_en = 1'b0;
      active = 1'b0;
      bankA_full = 1'b0;
      bankB_full = 1'b0;
      {R_inRegA, G_inRegA, B_inRegA} = '0;
      {R_inRegB, G_inRegB, B_inRegB} = '0;
      for (int i = 0; i < PIXELS; i++) begin
         pa = px_a(i);
         pb = px_b(i);
         R_inRegA = {pa[23:16], R_inRegA[8*PIXELS-1:8]};
         G_inRegA = {pa[15:8],  G_inRegA[8*PIXELS-1:8]};
         B_inRegA = {pa[7:0],   B_inRegA[8*PIXELS-1:8]};
         R_inRegB = {pb[23:16], R_inRegB[8*PIXELS-1:8]};
         G_inRegB = {pb[15:8],  G_inRegB[8*PIXELS-1:8]};
         B_inRegB = {pb[7:0],   B_inRegB[8*PIXELS-1:8]};
      end

      // Reset for two clocks
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      chk_out("reset", 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_cnt("reset", '0);

      // Startup: A full, selector 1 -> 0, first output still black
      reset = 1'b0;
      bankA_full = 1'b1;
      cyc(1'b1, 1'b1);
      chk_out("start", 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Bank A streams; B becomes full mid-bank for a seamless swap
      for (int k = 0; k < PIXELS; k++) begin
         if (k == 8) bankB_full = 1'b1;
         cyc(1'b1, 1'b1);
         chk_out($sformatf("A1 px%0d", k), px_a(k), 1'b1, k == 15, 1'b0, k == 15);
      end
      bankA_full = 1'b0;

      // Bank B follows pixel 15 of A with no gap; A refilled mid-bank
      for (int k = 0; k < PIXELS; k++) begin
         if (k == 4) bankA_full = 1'b1;
         cyc(1'b1, 1'b1);
         chk_out($sformatf("B1 px%0d", k), px_b(k), 1'b1, k == 15, 1'b0, k != 15);
      end
      bankB_full = 1'b0;

      // Bank A again; B never becomes full so the end of A stalls
      for (int k = 0; k < PIXELS; k++) begin
         cyc(1'b1, 1'b1);
         chk_out($sformatf("A2 px%0d", k), px_a(k), 1'b1, k == 15, 1'b0, 1'b0);
      end

      // Five underrun slots
      for (int n = 1; n <= 5; n++) begin
         cyc(1'b1, 1'b1);
         chk_out($sformatf("stall%0d", n), 24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk_cnt($sformatf("stall%0d", n), exp_cnt(n));
      end

      // B becomes full on a non-slot cycle: selector toggles, outputs hold
      bankA_full = 1'b0;
      bankB_full = 1'b1;
      cyc(1'b0, 1'b1);
      chk_out("resume", 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_cnt("resume", exp_cnt(5));

      // Bank B at half rate with four blanking slots after pixel 5
      for (int k = 0; k < PIXELS; k++) begin
         if (k == 6) begin
            for (int j = 0; j < 4; j++) begin
               cyc(1'b1, 1'b0);
               chk_out($sformatf("blank%0d", j), 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
               cyc(1'b0, 1'b1);
               chk_out($sformatf("blank%0d hold", j), 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
         end
         if (k == 10) bankA_full = 1'b1;
         cyc(1'b1, 1'b1);
         chk_out($sformatf("B2 px%0d", k), px_b(k), 1'b1, k == 15, 1'b0, k != 15);
         cyc(1'b0, 1'b1);
         chk_out($sformatf("B2 px%0d hold", k), px_b(k), 1'b1, 1'b0, 1'b0, k != 15);
      end
      chk_cnt("after blank", exp_cnt(5));

      // Bank A, then swap to B
      bankB_full = 1'b0;
      for (int k = 0; k < PIXELS; k++) begin
         if (k == 8) bankB_full = 1'b1;
         cyc(1'b1, 1'b1);
         chk_out($sformatf("A3 px%0d", k), px_a(k), 1'b1, k == 15, 1'b0, k == 15);
      end
      bankA_full = 1'b0;

      // Bank B pixels 0..7, then reset mid-stream
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b1);
         chk_out($sformatf("B3 px%0d", k), px_b(k), 1'b1, 1'b0, 1'b0, 1'b1);
      end
      reset = 1'b1;
      cyc(1'b1, 1'b1);
      chk_out("midreset", 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_cnt("midreset", '0);

      // Back in IDLE: B full is ignored, slots are black without underrun
      reset = 1'b0;
      for (int j = 0; j < 2; j++) begin
         cyc(1'b1, 1'b1);
         chk_out($sformatf("idle%0d", j), 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      end

      // Re-raise A full: pixel 0 of A is the first output
      bankA_full = 1'b1;
      bankB_full = 1'b0;
      cyc(1'b1, 1'b1);
      chk_out("restart", 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < PIXELS; k++) begin
         cyc(1'b1, 1'b1);
         chk_out($sformatf("A4 px%0d", k), px_a(k), 1'b1, k == 15, 1'b0, 1'b0);
      end

      // Twenty underrun slots saturate the 4-bit counter
      for (int n = 1; n <= 20; n++) begin
         cyc(1'b1, 1'b1);
         chk_out($sformatf("sat%0d", n), 24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk_cnt($sformatf("sat%0d", n), exp_cnt(n));
      end

      // Full coincides with a slot: still an underrun pixel, swap happens, count holds
      bankB_full = 1'b1;
      cyc(1'b1, 1'b1);
      chk_out("sat swap", 24'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk_cnt("sat swap", exp_cnt(21));
      cyc(1'b1, 1'b1);
      chk_out("sat B px0", px_b(0), 1'b1, 1'b0, 1'b0, 1'b1);
      chk_cnt("sat B px0", exp_cnt(21));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_line_reader.md
# vga_line_reader

Downstream consumer of the merge stage's ping-pong pixel banks. Owns `readVgaSelector`, serialises the 16 packed 8-bit pixels of the bank currently selected for reading onto a per-pixel RGB output at the VGA pixel-enable rate, and hands the consumed bank back to merge for refilling. Detects and flags underrun when the next bank is not ready at swap time.

## Interface
Parameters:
- `PIXELS` — 16 — pixels per bank; bus width is `8*PIXELS`.
- `CNT_W` — 16 — width of the underrun counter.

Ports:
- `clk` in 1 — single system clock; all logic on rising edge.
- `reset` in 1 — synchronous, active-high.
- `pix_en` in 1 — pixel-rate clock enable.
- `active` in 1 — display-active region; sampled with `pix_en`.
- `R_inRegA`, `G_inRegA`, `B_inRegA` in 128 — bank A channels; pixel i in bits [8i+7:8i].
- `R_inRegB`, `G_inRegB`, `B_inRegB` in 128 — bank B channels, same packing.
- `bankA_full`, `bankB_full` in 1 — level; bank completely written by merge.
- `readVgaSelector` out 1 — 0 = read A, merge fills B; 1 = read B, merge fills A.
- `R_out`, `G_out`, `B_out` out 8 — current pixel.
- `pixel_valid` out 1 — output pixel is real bank data.
- `bank_done` out 1 — one-cycle pulse; the read bank was fully consumed.
- `underrun` out 1 — one-cycle pulse per black pixel emitted during a stall.
- `underrun_count` out CNT_W — saturating count of underrun pixels.

## Operation
- An emit slot is any cycle with `pix_en`=1 and `active`=1. Cycles with `pix_en`=1 and `active`=0 drive RGB=0 and `pixel_valid`=0, hold the index, and raise no underrun.
- The pixel index `idx` is 4 bits (0..PIXELS-1). Pixel 0 is emitted first. The index wraps 15→0 only on a bank swap.
- States:
  - IDLE (reset state): `readVgaSelector`=1, so merge fills A. Outputs are 0. On `bankA_full`=1, go to STREAM with selector=0 and idx=0. Emit slots in IDLE output black with no underrun.
  - STREAM: each emit slot outputs the selected bank's pixel `idx` with `pixel_valid`=1, then `idx`++.
    - At the slot emitting idx=15, pulse `bank_done`.
    - If the other bank's `_full` is 1 in that cycle, toggle the selector, set idx=0, and stay in STREAM.
    - Otherwise go to STALL without toggling.
  - STALL: each emit slot outputs RGB=0 with `pixel_valid`=0, pulses `underrun`, and increments `underrun_count`.
    - When the other bank's `_full`=1, toggle the selector, set idx=0, and go to STREAM.
    - If `_full` and an emit slot coincide, the toggle happens that cycle and the slot is still an underrun pixel.
- Selector changes only at the swap point, never mid-bank.
- `underrun_count` saturates at all-ones and is cleared only by reset.

## Timing
- All outputs are registered. A pixel sampled in the emit-slot cycle appears on `R_out/G_out/B_out/pixel_valid` at the next rising edge (latency 1). Outputs hold between slots.
- `bank_done` is asserted in the same output cycle as pixel 15 and is high for exactly one clk.
- `readVgaSelector` changes on the edge after the idx=15 slot, i.e. in the same cycle pixel 15 is presented. The first pixel of the new bank is taken at the next emit slot.
- Back-to-back `pix_en` every cycle is supported with no bubble at the swap.
- Reset mid-operation: on the next edge, go to IDLE. Outputs are 0, selector=1, idx=0, and `underrun_count`=0. Any in-flight bank is discarded.
- Reset values: `readVgaSelector`=1; all other outputs 0.

## Configuration
- `VGA_UNDERRUN_COUNT_EN` defined: the CNT_W-bit saturating counter is implemented and drives `underrun_count`.
- Not defined: no counter logic is built and `underrun_count` is tied to 0. The `underrun` pulse behaves identically in both builds.

## Test plan
- **Startup:** reset for 2 clks, then `bankA_full`=1 with A pixels R=0x17, `pix_en` every cycle, `active`=1.
  - Selector goes 1→0.
  - 16 consecutive valid pixels follow, R=0x17.
  - `bank_done` pulses with pixel 15.
- **Seamless swap:** `bankB_full`=1 before A is finished, with B pixel 0 = (0x87,0x32,0x50).
  - The selector toggles to 1 and pixel 0 of B follows pixel 15 of A with no gap.
  - `underrun`=0 throughout.
- **Underrun:** `bankB_full`=0 at the end of A, held for 5 emit slots, then set to 1.
  - 5 black pixels are emitted, each with `underrun` pulses.
  - `underrun_count`=5 (0 when the macro is off).
  - Selector toggles to 1, then B streams.
- **Blanking and rate:** `pix_en` every 2nd cycle, with `active`=0 for 4 slots mid-bank.
  - Outputs are black and invalid during blanking and `idx` holds.
  - The bank still emits exactly 16 valid pixels.
- **Reset mid-stream:** reset asserted at pixel 7 of bank B.
  - Next cycle: selector=1, RGB=0, `pixel_valid`=0, counter=0, state IDLE.
  - After re-raising `bankA_full`, pixel 0 of A is the first output.
- **Saturation** (`CNT_W`=4, macro on): 20 underrun slots → `underrun_count`=15 and it holds.
